// File: rtl/cla_seq_adder_if.sv
// Request/result bundle for cla_seq_adder.
// Optional macro: CLA_SEQ_OVF_EN adds the signed-overflow flag ovf.
//   start  requester -> adder   request, honoured only when the adder is idle or done
//   a, b   requester -> adder   operands, captured on the accepting edge
//   c_in   requester -> adder   carry-in, captured on the accepting edge
//   busy   adder -> requester   high while nibbles are being processed
//   done   adder -> requester   one-cycle result-valid pulse
//   sum    adder -> requester   result, held until the next accepted start
//   c_out  adder -> requester   carry out of the MSB, held with sum
//   ovf    adder -> requester   signed overflow, held with sum (optional)
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: operands are latched and fed one nibble per
// clock through a single 4-bit carry-lookahead stage, with the carry registered
// between nibbles and the sum assembled in a shift register.
// Optional macro: CLA_SEQ_OVF_EN enables the registered signed-overflow output.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   slave side of cla_seq_adder_if (start/a/b/c_in in; busy/done/sum/c_out[/ovf] out)
module cla_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  cla_seq_adder_if.slave  bus
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   nib_cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
`ifdef CLA_SEQ_OVF_EN
  logic               ovf_q;
`endif

  // 4-bit carry-lookahead stage on the current low nibble
  logic [3:0] cla_g;
  logic [3:0] cla_p;
  logic [3:0] cla_c;
  logic [3:0] cla_s;

  always_comb begin
    cla_g = a_sh[3:0] & b_sh[3:0];
    cla_p = a_sh[3:0] ^ b_sh[3:0];
    cla_c[0] = cla_g[0] | (cla_p[0] & carry_q);
    cla_c[1] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & carry_q);
    cla_c[2] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
             | (cla_p[2] & cla_p[1] & cla_p[0] & carry_q);
    cla_c[3] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
             | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
             | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & carry_q);
    cla_s = cla_p ^ {cla_c[2:0], carry_q};
  end

  // Next partial sum: new nibble enters from the MSB end
  logic [WIDTH-1:0] sum_next;
  assign sum_next = {cla_s, sum_sh[WIDTH-1:4]};

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      nib_cnt <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            nib_cnt <= '0;
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.c_in;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          sum_sh  <= sum_next;
          carry_q <= cla_c[3];
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          if (nib_cnt == CNT_W'(NIBBLES - 1)) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            nib_cnt <= '0;
            sum_q   <= sum_next;
            c_out_q <= cla_c[3];
`ifdef CLA_SEQ_OVF_EN
            // carry into the MSB differs from carry out of it
            ovf_q   <= cla_c[2] ^ cla_c[3];
`endif
          end else begin
            nib_cnt <= nib_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef CLA_SEQ_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16).
module tb_cla_seq_adder;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic read_ovf();
`ifdef CLA_SEQ_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request and observe the result window (bounded to 10 edges).
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output int busy_n, output int done_n);
    lat = 0; busy_n = 0; done_n = 0; s = '0; co = 1'b0; ov = 1'b0;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.c_in = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy) busy_n++;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat == 0) begin
          lat = k; s = bus.sum; co = bus.c_out; ov = read_ovf();
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b want 0", bus.c_out); end
`ifdef CLA_SEQ_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co, ov; int lat, bn, dn;
    run_op(16'h0001, 16'h000A, 1'b0, s, co, ov, lat, bn, dn);
    checks++; if (s !== 16'h000B) begin errors++; $display("FAIL basic_sum: got %h want 000b", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_c_out: got %b want 0", co); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_width: got %0d want 1", dn); end
  endtask

  task automatic test_carry_in();
    logic [15:0] s; logic co, ov; int lat, bn, dn;
    run_op(16'hFFFE, 16'h0001, 1'b1, s, co, ov, lat, bn, dn);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL cin_sum: got %h want 0000", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL cin_c_out: got %b want 1", co); end
    checks++; if (bn !== 4) begin errors++; $display("FAIL cin_busy_cycles: got %0d want 4", bn); end
  endtask

  task automatic test_ripple();
    logic [15:0] s; logic co, ov; int lat, bn, dn;
    run_op(16'h0FFF, 16'h0001, 1'b0, s, co, ov, lat, bn, dn);
    checks++; if (s !== 16'h1000) begin errors++; $display("FAIL ripple_sum: got %h want 1000", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL ripple_c_out: got %b want 0", co); end
  endtask

  // Runs right after test_ripple, so the held result is 0x1000.
  task automatic test_busy_ignore();
    logic [15:0] s; logic co; int lat, dn;
    lat = 0; dn = 0; s = '0; co = 1'b0;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", bus.busy); end
    checks++; if (bus.sum !== 16'h1000) begin errors++; $display("FAIL ignore_sum_held: got %h want 1000", bus.sum); end
    for (int k = 3; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dn++;
        if (lat == 0) begin lat = k; s = bus.sum; co = bus.c_out; end
      end
    end
    checks++; if (s !== 16'h2345) begin errors++; $display("FAIL ignore_sum: got %h want 2345", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL ignore_c_out: got %b want 0", co); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ignore_latency: got %0d want 4", lat); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, ov; int lat, bn, dn, dcount;
    dcount = 0;
    @(negedge clk);
    bus.a = 16'h5555; bus.b = 16'h1111; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL rstmid_sum: got %h want 0000", bus.sum); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcount++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL rstmid_no_activity: got %0d want 0", dcount); end
    run_op(16'h0009, 16'h0003, 1'b0, s, co, ov, lat, bn, dn);
    checks++; if (s !== 16'h000C) begin errors++; $display("FAIL rstmid_next_sum: got %h want 000c", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_next_latency: got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    logic seen; int lat;
    seen = 1'b0; lat = 0;
    @(negedge clk);
    bus.a = 16'h0100; bus.b = 16'h0200; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (bus.done) begin
          seen = 1'b1;
          checks++; if (bus.sum !== 16'h0300) begin errors++; $display("FAIL b2b_first_sum: got %h want 0300", bus.sum); end
          bus.a = 16'hABCD; bus.b = 16'h1234; bus.c_in = 1'b0; bus.start = 1'b1;
        end
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", seen); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_rerun_busy: got %b want 1", bus.busy); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.done && lat == 0) begin
        lat = k;
        checks++; if (bus.sum !== 16'hBE01) begin errors++; $display("FAIL b2b_second_sum: got %h want be01", bus.sum); end
      end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_latency: got %0d want 4", lat); end
  endtask

  task automatic test_all_ones();
    logic [15:0] s; logic co, ov; int lat, bn, dn;
    run_op(16'hFFFF, 16'hFFFF, 1'b1, s, co, ov, lat, bn, dn);
    checks++; if (s !== 16'hFFFF) begin errors++; $display("FAIL ones_sum: got %h want ffff", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL ones_c_out: got %b want 1", co); end
  endtask

`ifdef CLA_SEQ_OVF_EN
  task automatic test_ovf();
    logic [15:0] s; logic co, ov; int lat, bn, dn;
    run_op(16'h7FFF, 16'h0001, 1'b0, s, co, ov, lat, bn, dn);
    checks++; if (s !== 16'h8000) begin errors++; $display("FAIL ovf1_sum: got %h want 8000", s); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf1_ovf: got %b want 1", ov); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL ovf1_c_out: got %b want 0", co); end
    run_op(16'hFFFF, 16'h0001, 1'b0, s, co, ov, lat, bn, dn);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovf2_ovf: got %b want 0", ov); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL ovf2_c_out: got %b want 1", co); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_carry_in();
    test_ripple();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_all_ones();
`ifdef CLA_SEQ_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
